instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset and restart.
REQ-002 SHALL have parameter TIMEOUT, default 16, max WAIT cycles before fetch-timeout error.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  begin execution from IDLE or HALT.
REQ-006 SHALL have port imem_req  output  1  fetch request, level.
REQ-007 SHALL have port imem_addr  output  32  fetch address (= pc).
REQ-008 SHALL have port imem_valid  input  1  fetch data valid.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-010 SHALL have port dp_instr  output  32  instruction_word driven to DataPath.
REQ-011 SHALL have port dp_we  output  1  register-file write strobe to DataPath.
REQ-012 SHALL have ports pc (output, 32, current PC) and instr_count (output, 16, retired instructions).
REQ-013 SHALL have ports busy, halted and err (each output, 1).

Function
REQ-014 SHALL implement FSM IDLE, FETCH, WAIT, DECODE, EXEC, WB, HALT.
REQ-015 IDLE: busy=0; start=1 -> FETCH.
REQ-016 FETCH: imem_req=1, imem_addr=pc -> WAIT.
REQ-017 WAIT: imem_req held at 1; imem_valid=1 -> capture imem_rdata into IR, -> DECODE; imem_valid sampled only in WAIT.
REQ-018 WAIT: after TIMEOUT cycles without valid -> HALT, err=1.
REQ-019 DECODE: opcode 7'b0010011 or 7'b0110011 -> EXEC; 7'b1110011 -> HALT with err=0; any other opcode -> HALT with err=1.
REQ-020 EXEC: dp_instr=IR, dp_we=0, one cycle.
REQ-021 WB: dp_instr=IR, one cycle; dp_we=1 only if IR[11:7]!=0.
REQ-022 WB: pc<=pc+4, wrapping mod 2^32; instr_count increments and saturates at 16'hFFFF; next state FETCH.
REQ-023 Outside EXEC and WB, dp_instr SHALL be 32'h0000_0013 (NOP).
REQ-024 Minimum latency SHALL be 5 cycles per instruction (FETCH to WB, zero-wait memory).
REQ-025 busy=1 in every state except IDLE and HALT; start SHALL be ignored while busy.
REQ-026 HALT: halted=1; err held.
REQ-027 HALT with start=1: clear halted and err, pc<=RESET_PC, instr_count<=0, -> FETCH.
REQ-028 imem_valid high in any state other than WAIT SHALL be ignored.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, pc=RESET_PC, IR=NOP, dp_instr=NOP, and imem_req, dp_we, busy, halted, err and instr_count to 0.
REQ-030 Reset mid-fetch SHALL abandon the outstanding request; the late imem_valid is ignored in IDLE.
REQ-031 Operation SHALL resume on the first rising edge after rst=1, with start required.

Structure
REQ-032 A shared package SHALL hold the state enum, opcode constants (OP_IMM, OP, SYSTEM) and the NOP constant.
REQ-033 One combinational sub-module, instr_decode, SHALL produce is_alu, is_halt, is_illegal and rd_nonzero from IR; all sequencing SHALL stay in instr_sequencer.

Verification
REQ-034 Memory returns 32'h00107093 at pc 0, zero-wait, start pulse -> dp_instr=32'h00107093 in EXEC/WB, dp_we=1 for 1 cycle, pc=4, instr_count=1, 5 cycles after FETCH.
REQ-035 32'h00107013 then 32'h00100033 (rd=x0) -> dp_we stays 0 for both, pc=8, instr_count=2.
REQ-036 32'h00000073 fetched -> HALT, halted=1, err=0, busy=0; a later start -> pc=RESET_PC, FETCH.
REQ-037 imem_valid withheld for TIMEOUT cycles -> HALT with err=1; opcode 7'b1111111 -> HALT with err=1.
REQ-038 rst low during WAIT, imem_valid pulsed after rst high -> state IDLE, IR=NOP, pc=0, no dp_we.
REQ-039 pc preset near 32'hFFFF_FFFC via RESET_PC, one ALU instruction -> pc wraps to 32'h0000_0000.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer_pkg
//  Brief    : State encoding, opcode constants and the NOP word shared by the
//             instruction sequencer and its decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package instr_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_WAIT   = 3'd2,
      S_DECODE = 3'd3,
      S_EXEC   = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [6:0]  OP_IMM = 7'b0010011;
   localparam logic [6:0]  OP     = 7'b0110011;
   localparam logic [6:0]  SYSTEM = 7'b1110011;

   // addi x0, x0, 0
   localparam logic [31:0] NOP    = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : instr_decode
//  Brief    : Purely combinational classification of the held instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_decode
   import instr_sequencer_pkg::*;
(
   input  logic [11:0] ir_lo,
   output logic        is_alu,
   output logic        is_halt,
   output logic        is_illegal,
   output logic        rd_nonzero
);

   logic [6:0] w_opcode;

   assign w_opcode   = ir_lo[6:0];
   assign is_alu     = (w_opcode == OP_IMM) || (w_opcode == OP);
   assign is_halt    = (w_opcode == SYSTEM);
   assign is_illegal = !is_alu && !is_halt;
   assign rd_nonzero = (ir_lo[11:7] != 5'd0);

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer
//  Brief    : Multi-cycle fetch/decode/execute/writeback sequencer driving an
//             external instruction memory and a DataPath.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] dp_instr,
   output logic        dp_we,
   output logic [31:0] pc,
   output logic [15:0] instr_count,
   output logic        busy,
   output logic        halted,
   output logic        err
);

   localparam int unsigned     c_WCW       = $clog2(TIMEOUT + 1);
   localparam logic [c_WCW-1:0] c_WAIT_LAST = c_WCW'(TIMEOUT - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [31:0]        r_pc;
   logic [31:0]        r_ir;
   logic [15:0]        r_count;
   logic               r_err;
   logic [c_WCW-1:0]   r_wait_cnt;

   logic               w_is_alu;
   logic               w_is_halt;
   logic               w_is_illegal;
   logic               w_rd_nonzero;
   logic               w_timeout;

   instr_decode u_decode (
      .ir_lo      (r_ir[11:0]),
      .is_alu     (w_is_alu),
      .is_halt    (w_is_halt),
      .is_illegal (w_is_illegal),
      .rd_nonzero (w_rd_nonzero)
   );

   // Last permitted WAIT cycle; a valid on this cycle still wins over timeout.
   assign w_timeout = (r_wait_cnt == c_WAIT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (start) w_state_nxt = S_FETCH;
         S_FETCH:  w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (imem_valid)     w_state_nxt = S_DECODE;
            else if (w_timeout) w_state_nxt = S_HALT;
         end
         S_DECODE: w_state_nxt = w_is_alu ? S_EXEC : S_HALT;
         S_EXEC:   w_state_nxt = S_WB;
         S_WB:     w_state_nxt = S_FETCH;
         S_HALT:   if (start) w_state_nxt = S_FETCH;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc       <= RESET_PC;
         r_ir       <= NOP;
         r_count    <= 16'd0;
         r_err      <= 1'b0;
         r_wait_cnt <= '0;
      end else begin
         case (r_state)
            S_FETCH: r_wait_cnt <= '0;
            S_WAIT: begin
               if (imem_valid) begin
                  r_ir <= imem_rdata;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
                  if (w_timeout) r_err <= 1'b1;
               end
            end
            S_DECODE: begin
               if (w_is_halt)         r_err <= 1'b0;
               else if (w_is_illegal) r_err <= 1'b1;
            end
            S_WB: begin
               r_pc <= r_pc + 32'd4;
               if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
            end
            S_HALT: begin
               if (start) begin
                  r_pc    <= RESET_PC;
                  r_count <= 16'd0;
                  r_err   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign imem_req    = (r_state == S_FETCH) || (r_state == S_WAIT);
   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign dp_instr    = ((r_state == S_EXEC) || (r_state == S_WB)) ? r_ir : NOP;
   assign dp_we       = (r_state == S_WB) && w_rd_nonzero;
   assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
   assign halted      = (r_state == S_HALT);
   assign err         = r_err;
   assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_sequencer
//  Brief    : Self-checking bench: table vectors, corner sequences and random
//             programs compared against a program-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;
   import instr_sequencer_pkg::*;

   localparam int unsigned TO    = 16;
   localparam logic [31:0] RPC   = 32'h0000_0000;
   localparam logic [31:0] RPC2  = 32'hFFFF_FFFC;
   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam logic [31:0] NOPW  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        imem_req, dp_we, busy, halted, err;
   logic [31:0] imem_addr, dp_instr, pc;
   logic [15:0] instr_count;

   logic        start2 = 1'b0;
   logic        valid2 = 1'b0;
   logic [31:0] rdata2 = 32'd0;
   logic        req2, we2, busy2, halted2, err2;
   logic [31:0] addr2, dpi2, pc2;
   logic [15:0] cnt2;

   instr_sequencer #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .dp_instr(dp_instr), .dp_we(dp_we), .pc(pc), .instr_count(instr_count),
      .busy(busy), .halted(halted), .err(err)
   );

   instr_sequencer #(.RESET_PC(RPC2), .TIMEOUT(TO)) dut2 (
      .clk(clk), .rst(rst), .start(start2),
      .imem_req(req2), .imem_addr(addr2),
      .imem_valid(valid2), .imem_rdata(rdata2),
      .dp_instr(dpi2), .dp_we(we2), .pc(pc2), .instr_count(cnt2),
      .busy(busy2), .halted(halted2), .err(err2)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [31:0] prog   [0:63];
   int          lat_of [0:63];
   int  fetch_idx, we_pulses, steps, req_cycles;
   bit  prev_req, rand_start, stray, force_valid;

   typedef struct {
      logic [31:0] word;
      int          lat;
      int          steps;
      logic [31:0] pc;
      logic [15:0] cnt;
      int          we;
      logic        err;
   } vec_t;
   vec_t tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 64; i++) begin
         prog[i]   = 32'hFFFF_FFFF;
         lat_of[i] = 0;
      end
   endtask

   task automatic begin_prog();
      fetch_idx = 0; we_pulses = 0; steps = 0; prev_req = 1'b0; req_cycles = 0;
   endtask

   // One clock: observe at the falling edge, then drive memory responses.
   task automatic step();
      int          idx;
      int          l;
      logic [31:0] w;
      @(negedge clk);
      steps++;
      if (imem_req && !prev_req) begin
         check("fetch_addr", imem_addr, RPC + 32'(fetch_idx) * 32'd4);
         fetch_idx++;
      end
      if (imem_req || !busy) check("nop_outside_exec", dp_instr, NOPW);
      if (dp_we) begin
         we_pulses++;
         if (fetch_idx > 0 && fetch_idx <= 64) check("wb_instr", dp_instr, prog[fetch_idx-1]);
      end
      prev_req = imem_req;
      idx = int'((imem_addr - RPC) >> 2);
      if (idx >= 0 && idx < 64) begin w = prog[idx]; l = lat_of[idx]; end
      else begin w = 32'hFFFF_FFFF; l = 0; end
      if (force_valid) begin
         imem_valid = 1'b1; imem_rdata = 32'h0010_7093;
      end else if (imem_req) begin
         if (req_cycles >= l + 1) begin imem_valid = 1'b1; imem_rdata = w; end
         else if (req_cycles == 0 && stray) begin imem_valid = 1'($urandom % 2); imem_rdata = $urandom; end
         else begin imem_valid = 1'b0; imem_rdata = $urandom; end
         req_cycles++;
      end else begin
         req_cycles = 0;
         imem_valid = stray ? 1'($urandom % 2) : 1'b0;
         imem_rdata = $urandom;
      end
      start  = (rand_start && busy) ? 1'($urandom % 2) : 1'b0;
      valid2 = req2;
      rdata2 = 32'h0010_7093;
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_we", {31'd0, dp_we}, 32'd0);
      check("rst_dp_instr", dp_instr, NOPW);
      check("rst_pc", pc, RPC);
      check("rst_count", {16'd0, instr_count}, 32'd0);
      check("rst_pc2", pc2, RPC2);
      check("rst_busy2", {30'd0, busy2, halted2 | err2}, 32'd0);
      start = 1'b0; imem_valid = 1'b0; start2 = 1'b0; valid2 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      prev_req = 1'b0; req_cycles = 0;
   endtask

   task automatic run_prog(input string name, input int exp_steps, input logic [31:0] exp_pc,
                           input logic [15:0] exp_cnt, input int exp_we, input logic exp_err);
      begin_prog();
      start = 1'b1;
      do step(); while (!halted && steps < 4000);
      check({name, "_cycles"}, steps, exp_steps);
      check({name, "_halted"}, {31'd0, halted}, 32'd1);
      check({name, "_busy"}, {31'd0, busy}, 32'd0);
      check({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
      check({name, "_pc"}, pc, exp_pc);
      check({name, "_count"}, {16'd0, instr_count}, {16'd0, exp_cnt});
      check({name, "_we_pulses"}, we_pulses, exp_we);
   endtask

   // Program-level model: cycles from start to HALT, retired count, writes, error.
   function automatic void model(output int st, output logic [31:0] pc_e, output logic [15:0] cnt_e,
                                 output int we_e, output logic err_e);
      st = 1; pc_e = RPC; cnt_e = 16'd0; we_e = 0; err_e = 1'b0;
      for (int k = 0; k < 64; k++) begin
         if (lat_of[k] >= int'(TO)) begin st += 1 + int'(TO); err_e = 1'b1; return; end
         case (prog[k][6:0])
            7'h13, 7'h33: begin
               st += 5 + lat_of[k]; pc_e += 32'd4; cnt_e++;
               if (prog[k][11:7] != 5'd0) we_e++;
            end
            7'h73: begin st += 3 + lat_of[k]; return; end
            default: begin st += 3 + lat_of[k]; err_e = 1'b1; return; end
         endcase
      end
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          e_st, e_we;
      logic [31:0] e_pc, w;
      logic [15:0] e_cnt;
      logic        e_err;
      int          n, r;
      logic [6:0]  op;

      tbl[0] = '{32'h0010_7093, 0,       9, 32'd4, 16'd1, 1, 1'b0};
      tbl[1] = '{32'h0010_7013, 0,       9, 32'd4, 16'd1, 0, 1'b0};
      tbl[2] = '{32'h0010_0033, 2,      11, 32'd4, 16'd1, 0, 1'b0};
      tbl[3] = '{32'h0000_0073, 0,       4, 32'd0, 16'd0, 0, 1'b0};
      tbl[4] = '{32'hFFFF_FFFF, 0,       4, 32'd0, 16'd0, 0, 1'b1};
      tbl[5] = '{32'h0000_0003, 1,       5, 32'd0, 16'd0, 0, 1'b1};
      tbl[6] = '{32'h0010_8093, TO - 1, 24, 32'd4, 16'd1, 1, 1'b0};
      tbl[7] = '{32'h0010_7093, TO,     18, 32'd0, 16'd0, 0, 1'b1};
      tbl[8] = '{32'h0000_02B3, 3,      12, 32'd4, 16'd1, 1, 1'b0};

      rand_start = 1'b0; stray = 1'b1; force_valid = 1'b0;
      clear_prog();
      @(negedge clk);
      do_reset();

      // Single ALU instruction, zero-wait: cycle-by-cycle view.
      clear_prog();
      prog[0] = 32'h0010_7093; prog[1] = ECALL;
      begin_prog();
      start = 1'b1;
      step();
      check("seq_fetch_req", {31'd0, imem_req}, 32'd1);
      check("seq_fetch_busy", {31'd0, busy}, 32'd1);
      step(); step(); step();
      check("seq_exec_instr", dp_instr, 32'h0010_7093);
      check("seq_exec_we", {31'd0, dp_we}, 32'd0);
      step();
      check("seq_wb_instr", dp_instr, 32'h0010_7093);
      check("seq_wb_we", {31'd0, dp_we}, 32'd1);
      step();
      check("seq_pc_after", pc, 32'd4);
      check("seq_count_after", {16'd0, instr_count}, 32'd1);
      while (!halted && steps < 200) step();
      check("seq_halted", {31'd0, halted}, 32'd1);
      check("seq_we_pulses", we_pulses, 1);

      // Table: each word followed by ECALL, restarting from HALT every time.
      foreach (tbl[i]) begin
         clear_prog();
         prog[0] = tbl[i].word; lat_of[0] = tbl[i].lat; prog[1] = ECALL;
         run_prog($sformatf("tbl%0d", i), tbl[i].steps, tbl[i].pc, tbl[i].cnt, tbl[i].we, tbl[i].err);
      end
      do_reset();

      // Two retiring instructions, both writing x0.
      clear_prog();
      prog[0] = 32'h0010_7013; prog[1] = 32'h0010_0033; prog[2] = ECALL;
      run_prog("rd_x0_pair", 14, 32'd8, 16'd2, 0, 1'b0);

      // Reset while the second fetch is waiting; late valids must be ignored.
      clear_prog();
      prog[0] = 32'h0010_7093; prog[1] = 32'h0010_8093; lat_of[1] = 10; prog[2] = ECALL;
      begin_prog();
      start = 1'b1;
      repeat (8) step();
      check("midwait_pc", pc, 32'd4);
      check("midwait_req", {31'd0, imem_req}, 32'd1);
      do_reset();
      force_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("post_rst_idle", {30'd0, busy, dp_we}, 32'd0);
         check("post_rst_pc", pc, RPC);
      end
      force_valid = 1'b0;
      clear_prog();
      prog[0] = 32'h0010_7093; prog[1] = ECALL;
      run_prog("post_rst_run", 9, 32'd4, 16'd1, 1, 1'b0);

      // PC wrap on the instance preset to the top of the address space.
      do_reset();
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      check("wrap_fetch_addr", addr2, RPC2);
      check("wrap_fetch_req", {31'd0, req2}, 32'd1);
      repeat (4) step();
      check("wrap_wb_we", {31'd0, we2}, 32'd1);
      check("wrap_wb_instr", dpi2, 32'h0010_7093);
      step();
      check("wrap_pc", pc2, 32'd0);
      check("wrap_count", {16'd0, cnt2}, 32'd1);

      // Random programs against the program-level model.
      rand_start = 1'b1;
      for (int p = 0; p < 16; p++) begin
         clear_prog();
         n = 1 + int'($urandom % 8);
         for (int k = 0; k <= n; k++) begin
            r = int'($urandom % 12);
            if (r < 8)       lat_of[k] = int'($urandom % 4);
            else if (r == 8) lat_of[k] = int'(TO) - 1;
            else if (r == 9) lat_of[k] = int'(TO);
            else             lat_of[k] = 0;
            w = $urandom;
            if (k < n) begin
               w[6:0]  = ($urandom % 2) ? 7'h13 : 7'h33;
               if ($urandom % 3 == 0) w[11:7] = 5'd0;
            end else if ($urandom % 2) begin
               w[6:0] = 7'h73;
            end else begin
               do op = 7'($urandom); while (op == 7'h13 || op == 7'h33 || op == 7'h73);
               w[6:0] = op;
            end
            prog[k] = w;
         end
         model(e_st, e_pc, e_cnt, e_we, e_err);
         run_prog($sformatf("rand%0d", p), e_st, e_pc, e_cnt, e_we, e_err);
      end
      rand_start = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
